// File: rtl/jt6295_cmd_pkg.sv
// Shared types for the jt6295 command sequencer: FSM encoding, request record
// and command-byte builders.
package jt6295_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CHK  = 3'd1,
        ST_W1   = 3'd2,
        ST_G1   = 3'd3,
        ST_W2   = 3'd4,
        ST_G2   = 3'd5
    } state_t;

    typedef struct packed {
        logic       stop;
        logic [1:0] ch;
        logic [6:0] phrase;
        logic [3:0] att;
    } req_t;

    localparam int REQ_W       = $bits(req_t);
    localparam int PLAY_BIT    = 7;
    localparam int STOP_CH_LSB = 3;
    localparam int ATT_CH_LSB  = 4;

    function automatic logic [3:0] ch_onehot(input logic [1:0] ch);
        return 4'b0001 << ch;
    endfunction

    function automatic logic [7:0] stop_byte(input logic [1:0] ch);
        logic [7:0] b;
        b = '0;
        b[STOP_CH_LSB +: 4] = ch_onehot(ch);
        return b;
    endfunction

    function automatic logic [7:0] play_byte1(input logic [6:0] phrase);
        logic [7:0] b;
        b = {1'b0, phrase};
        b[PLAY_BIT] = 1'b1;
        return b;
    endfunction

    function automatic logic [7:0] play_byte2(input logic [1:0] ch, input logic [3:0] att);
        logic [7:0] b;
        b = {4'b0000, att};
        b[ATT_CH_LSB +: 4] = ch_onehot(ch);
        return b;
    endfunction

endpackage

// File: rtl/jt6295_cmdfifo.sv
// Synchronous request FIFO; one extra pointer bit distinguishes full from empty.
module jt6295_cmdfifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign wr_ok   = wr & ~full;
    assign rd_ok   = rd & ~empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/jt6295_cmdseq.sv
// Sequences queued play/stop requests into jt6295 write cycles paced by the
// sample strobe, pre-empting a busy channel after a bounded wait.
//
// state | meaning
// IDLE  | waiting for a queued request
// CHK   | decode request, wait for channel idle (or time out and pre-empt)
// W1    | first byte: wrn falls on a strobe, rises on the next
// G1    | one sample period gap after the first byte
// W2    | second byte low period (entered with wrn already low)
// G2    | gap after the second byte
module jt6295_cmdseq import jt6295_cmd_pkg::*; #(
    parameter int FIFO_DEPTH = 4,
    parameter int WAIT_MAX   = 255
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       sample,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_stop,
    input  logic [1:0] req_ch,
    input  logic [6:0] req_phrase,
    input  logic [3:0] req_att,
    output logic       wrn,
    output logic [7:0] din,
    input  logic [7:0] dout,
    output logic       busy,
    output logic       preempt
);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     st, st_nx;
    req_t       req_in, head, cur;
    logic       fifo_full, fifo_empty, pop, ready_en;
    logic [7:0] byte1, byte2, din_q, wait_cnt;
    logic       has_second, pre_stop, wr_low, preempt_q;
    logic [3:0] ch_flags;
    logic       ch_busy, wait_done;
    logic       unused_dout;

    assign req_in      = '{stop: req_stop, ch: req_ch, phrase: req_phrase, att: req_att};
    assign req_ready   = ready_en & ~fifo_full;
    assign pop         = (st == ST_IDLE) & ~fifo_empty;
    assign ch_flags    = dout[3:0];
    assign ch_busy     = ch_flags[cur.ch];
    assign wait_done   = sample & (wait_cnt == WAIT_LAST);
    assign unused_dout = ^dout[7:4];

    jt6295_cmdfifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .rst     (rst),
        .clk     (clk),
        .wr      (req_valid & req_ready),
        .wr_data (req_in),
        .rd      (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= ST_IDLE;
        else      st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        case (st)
            ST_IDLE: if (!fifo_empty) st_nx = ST_CHK;
            ST_CHK:  if (cur.stop || !ch_busy || wait_done) st_nx = ST_W1;
            ST_W1:   if (sample && wr_low) st_nx = ST_G1;
            ST_G1:   if (sample) st_nx = has_second ? ST_W2 : (pre_stop ? ST_CHK : ST_IDLE);
            ST_W2:   if (sample) st_nx = ST_G2;
            ST_G2:   if (sample) st_nx = ST_IDLE;
            default: st_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur        <= '0;
            byte1      <= '0;
            byte2      <= '0;
            din_q      <= '0;
            wait_cnt   <= '0;
            has_second <= 1'b0;
            pre_stop   <= 1'b0;
            wr_low     <= 1'b0;
            preempt_q  <= 1'b0;
            ready_en   <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            preempt_q <= 1'b0;
            case (st)
                ST_IDLE: if (!fifo_empty) begin
                    cur      <= head;
                    wait_cnt <= '0;
                end
                ST_CHK: begin
                    if (cur.stop) begin
                        byte1      <= stop_byte(cur.ch);
                        has_second <= 1'b0;
                        pre_stop   <= 1'b0;
                    end else if (!ch_busy) begin
                        byte1      <= play_byte1(cur.phrase);
                        byte2      <= play_byte2(cur.ch, cur.att);
                        has_second <= 1'b1;
                        pre_stop   <= 1'b0;
                        wait_cnt   <= '0;
                    end else if (wait_done) begin
                        // channel stayed busy too long: stop it, then retry the play
                        byte1      <= stop_byte(cur.ch);
                        has_second <= 1'b0;
                        pre_stop   <= 1'b1;
                        wait_cnt   <= '0;
                        preempt_q  <= 1'b1;
                    end else if (sample) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_W1: if (sample) begin
                    if (!wr_low) begin
                        wr_low <= 1'b1;
                        din_q  <= byte1;
                    end else begin
                        wr_low <= 1'b0;
                    end
                end
                ST_G1: if (sample && has_second) begin
                    wr_low <= 1'b1;
                    din_q  <= byte2;
                end
                ST_W2: if (sample) wr_low <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        wrn     = ~wr_low;
        din     = din_q;
        busy    = ~((st == ST_IDLE) & fifo_empty);
        preempt = preempt_q;
    end

endmodule

// File: tb/tb_jt6295_cmdseq.sv
// Scoreboard bench for jt6295_cmdseq: expected command bytes are queued at
// enqueue time and popped on every falling edge of wrn.
module tb_jt6295_cmdseq;
    logic       rst = 1'b0;
    logic       clk = 1'b0;
    logic       sample = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_stop = 1'b0;
    logic [1:0] req_ch = '0;
    logic [6:0] req_phrase = '0;
    logic [3:0] req_att = '0;
    logic [7:0] dout = '0;
    logic       req_ready, wrn, busy, preempt;
    logic [7:0] din;

    int n_err = 0;
    int n_chk = 0;

    logic [7:0] exp_q[$];
    int  sph = 0;
    int  cyc = 0;
    int  n_writes = 0;
    int  n_preempt = 0;
    int  n_strobes = 0;
    int  strobes_at_preempt = 0;
    int  low_len = 0;
    int  last_rise = 0;
    int  last_gap = 0;
    logic prev_wrn = 1'b1;
    logic unstable = 1'b0;
    logic [7:0] din_at_fall = '0;

    jt6295_cmdseq #(.FIFO_DEPTH(4), .WAIT_MAX(4)) dut (
        .rst        (rst),
        .clk        (clk),
        .sample     (sample),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_stop   (req_stop),
        .req_ch     (req_ch),
        .req_phrase (req_phrase),
        .req_att    (req_att),
        .wrn        (wrn),
        .din        (din),
        .dout       (dout),
        .busy       (busy),
        .preempt    (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // one sample strobe every 4 clocks
    initial begin
        forever begin
            @(posedge clk);
            #1;
            sph = (sph + 1) % 4;
            sample = (sph == 0);
        end
    end

    // write monitor and scoreboard consumer
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (sample) n_strobes++;
            if (!rst) begin
                prev_wrn = 1'b1;
                low_len  = 0;
            end else begin
                if (preempt) begin
                    n_preempt++;
                    strobes_at_preempt = n_strobes;
                end
                if (prev_wrn && !wrn) begin
                    check("sb_nonempty", (exp_q.size() != 0) ? 1 : 0, 1);
                    if (exp_q.size() != 0) check("din", din, exp_q.pop_front());
                    din_at_fall = din;
                    unstable    = 1'b0;
                    low_len     = 1;
                    last_gap    = cyc - last_rise;
                    n_writes++;
                end else if (!wrn) begin
                    low_len++;
                    if (din !== din_at_fall) unstable = 1'b1;
                end else if (!prev_wrn && wrn) begin
                    check("wrn_low_len", low_len, 4);
                    check("din_stable", unstable, 0);
                    last_rise = cyc;
                end
                prev_wrn = wrn;
            end
        end
    end

    task automatic enqueue(input bit stop, input bit [1:0] ch, input bit [6:0] ph,
                           input bit [3:0] att, input bit pre, output int waited);
        logic [7:0] b;
        req_valid  = 1'b1;
        req_stop   = stop;
        req_ch     = ch;
        req_phrase = ph;
        req_att    = att;
        waited     = 0;
        while (!req_ready && waited < 500) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 500) check("enq_timeout", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        b = 8'h08 << ch;
        if (pre || stop) exp_q.push_back(b);
        if (!stop) begin
            exp_q.push_back({1'b1, ph});
            b = {4'b0001 << ch, att};
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while ((busy || !wrn) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        int w, w0, p0, s0, n;
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w0, p0, s0, n;
        // reset state
        repeat (3) @(negedge clk);
        check("rst_wrn", wrn, 1);
        check("rst_din", din, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_preempt", preempt, 0);
        rst = 1'b1;
        #1;
        check("ready_before_clk", req_ready, 0);
        @(posedge clk);
        #1;
        check("ready_after_clk", req_ready, 1);

        // play phrase 2, ch 0, att 0
        enqueue(1'b0, 2'd0, 7'd2, 4'd0, 1'b0, w);
        wait_idle("play_idle");
        check("play_gap", last_gap, 4);
        check("play_drained", exp_q.size(), 0);

        // stop ch 2: one write only
        w0 = n_writes;
        enqueue(1'b1, 2'd2, 7'd0, 4'd0, 1'b0, w);
        wait_idle("stop_idle");
        check("stop_writes", n_writes - w0, 1);

        // play ch 1 while channel busy: pre-empt after 4 strobes
        dout = 8'h02;
        p0 = n_preempt;
        w0 = n_writes;
        s0 = n_strobes;
        enqueue(1'b0, 2'd1, 7'd5, 4'd3, 1'b1, w);
        n = 0;
        while (n_writes == w0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("preempt_stop_seen", (n_writes > w0) ? 1 : 0, 1);
        dout = 8'h00;
        wait_idle("preempt_idle");
        check("preempt_count", n_preempt - p0, 1);
        check("preempt_strobes",
              ((strobes_at_preempt - s0) >= 4 && (strobes_at_preempt - s0) <= 5) ? 1 : 0, 1);
        check("preempt_writes", n_writes - w0, 3);

        // back-to-back requests against a depth-4 queue
        enqueue(1'b1, 2'd3, 7'd0, 4'd0, 1'b0, w);
        repeat (2) @(posedge clk);
        #1;
        enqueue(1'b1, 2'd0, 7'd0, 4'd0, 1'b0, w);
        enqueue(1'b0, 2'd3, 7'h7f, 4'hf, 1'b0, w);
        enqueue(1'b1, 2'd1, 7'd0, 4'd0, 1'b0, w);
        enqueue(1'b0, 2'd2, 7'd1, 4'd5, 1'b0, w);
        check("full_ready", req_ready, 0);
        enqueue(1'b1, 2'd2, 7'd0, 4'd0, 1'b0, w);
        check("fifth_waited", (w > 0) ? 1 : 0, 1);
        wait_idle("burst_idle");
        check("burst_drained", exp_q.size(), 0);

        // reset while wrn is low
        enqueue(1'b0, 2'd0, 7'd9, 4'd1, 1'b0, w);
        enqueue(1'b1, 2'd1, 7'd0, 4'd0, 1'b0, w);
        enqueue(1'b1, 2'd3, 7'd0, 4'd0, 1'b0, w);
        n = 0;
        while (wrn && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wrn_low_seen", wrn, 0);
        #3;
        rst = 1'b0;
        #1;
        check("abort_wrn", wrn, 1);
        check("abort_busy", busy, 0);
        check("abort_ready", req_ready, 0);
        check("abort_din", din, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        w0 = n_writes;
        repeat (60) @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_writes", n_writes - w0, 0);
        check("post_rst_ready", req_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
